// File: rtl/rodada_pkg.sv
// Shared types and constants for the reaction-round block.
package rodada_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ESPERA,
    JOGO,
    FIM
  } estado_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_passo(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rodada_if.sv
// Round control and result signals, grouped for the round controller.
interface rodada_if;
  logic       start;
  logic       b1;
  logic       b2;
  logic       go_led;
  logic       p1vic;
  logic       p2vic;
  logic       busy;
  logic [1:0] falsa;
  logic       nulo;

  modport master (
    output start, b1, b2,
    input  go_led, p1vic, p2vic, busy, falsa, nulo
  );

  modport slave (
    input  start, b1, b2,
    output go_led, p1vic, p2vic, busy, falsa, nulo
  );
endinterface

// File: rtl/rodada_reacao_fsm.sv
// Round controller: random wait, go window, false-start and timeout handling.
module rodada_reacao_fsm
  import rodada_pkg::*;
#(
  parameter int unsigned DELAY_MIN = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  press1_i,
  input  logic  press2_i,
  rodada_if.slave bus
);
  estado_t    estado_q, estado_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q;
  logic       go_q, go_d;
  logic       p1_q, p1_d;
  logic       p2_q, p2_d;
  logic [1:0] falsa_q, falsa_d;
  logic       nulo_q, nulo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      go_q     <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      falsa_q  <= '0;
      nulo_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_passo(lfsr_q);
      go_q     <= go_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      falsa_q  <= falsa_d;
      nulo_q   <= nulo_d;
    end
  end

  // Presses take priority over the counter reaching zero in the same cycle.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    go_d     = go_q;
    p1_d     = 1'b0;
    p2_d     = 1'b0;
    falsa_d  = falsa_q;
    nulo_d   = nulo_q;
    case (estado_q)
      IDLE: begin
        if (bus.start) begin
          estado_d = ESPERA;
          falsa_d  = '0;
          nulo_d   = 1'b0;
          cnt_d    = 9'(DELAY_MIN) + {1'b0, lfsr_q};
        end
      end
      ESPERA: begin
        if (press1_i && press2_i) begin
          falsa_d  = 2'b11;
          nulo_d   = 1'b1;
          estado_d = FIM;
        end else if (press1_i) begin
          falsa_d[0] = 1'b1;
          p2_d       = 1'b1;
          estado_d   = FIM;
        end else if (press2_i) begin
          falsa_d[1] = 1'b1;
          p1_d       = 1'b1;
          estado_d   = FIM;
        end else if (cnt_q == '0) begin
          go_d     = 1'b1;
          cnt_d    = 9'(TIMEOUT - 1);
          estado_d = JOGO;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      JOGO: begin
        if (press1_i || press2_i || cnt_q == '0) begin
          go_d     = 1'b0;
          estado_d = FIM;
          if (press1_i && !press2_i) begin
            p1_d = 1'b1;
          end else if (press2_i && !press1_i) begin
            p2_d = 1'b1;
          end else begin
            nulo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      FIM:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  assign bus.go_led = go_q;
  assign bus.p1vic  = p1_q;
  assign bus.p2vic  = p2_q;
  assign bus.busy   = (estado_q != IDLE);
  assign bus.falsa  = falsa_q;
  assign bus.nulo   = nulo_q;
endmodule

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer followed by rising-edge detect; one-cycle press pulse.
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic botao_i,
  output logic pulso_o
);
  logic s1_q, s2_q, ant_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      ant_q <= 1'b0;
    end else begin
      s1_q  <= botao_i;
      s2_q  <= s1_q;
      ant_q <= s2_q;
    end
  end

  assign pulso_o = s2_q & ~ant_q;
endmodule

// File: rtl/rodada_reacao.sv
// Two-player reaction round: button conditioning plus round controller.
module rodada_reacao #(
  parameter int unsigned DELAY_MIN = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       b1,
  input  logic       b2,
  output logic       go_led,
  output logic       p1vic,
  output logic       p2vic,
  output logic       busy,
  output logic [1:0] falsa,
  output logic       nulo
);
  rodada_if u_bus ();
  logic press1, press2;

  assign u_bus.start = start;
  assign u_bus.b1    = b1;
  assign u_bus.b2    = b2;

  sincroniza_borda u_sinc1 (
    .clock   (clock),
    .reset   (reset),
    .botao_i (u_bus.b1),
    .pulso_o (press1)
  );

  sincroniza_borda u_sinc2 (
    .clock   (clock),
    .reset   (reset),
    .botao_i (u_bus.b2),
    .pulso_o (press2)
  );

  rodada_reacao_fsm #(
    .DELAY_MIN (DELAY_MIN),
    .TIMEOUT   (TIMEOUT)
  ) u_fsm (
    .clock    (clock),
    .reset    (reset),
    .press1_i (press1),
    .press2_i (press2),
    .bus      (u_bus)
  );

  assign go_led = u_bus.go_led;
  assign p1vic  = u_bus.p1vic;
  assign p2vic  = u_bus.p2vic;
  assign busy   = u_bus.busy;
  assign falsa  = u_bus.falsa;
  assign nulo   = u_bus.nulo;
endmodule
